// File: rtl/matrix_scan_fsm.sv
// Sequencer for a row-major pixel-matrix scan: drives the external row/column
// counters, settles each pixel, triggers an ADC conversion and stores the sample.
module matrix_scan_fsm #(
  parameter int CW          = 2,
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          adc_done_i,
  input  logic [CW-1:0] row_cnt_i,
  input  logic [CW-1:0] col_cnt_i,
  output logic [1:0]    opc_row_o,
  output logic [1:0]    opc_col_o,
  output logic          adc_start_o,
  output logic          wr_en_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int SW = (SETTLE_CYC  > 1) ? $clog2(SETTLE_CYC)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  // Timers count down to zero, so the load value is one less than the duration.
  localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TMO_LD    = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  localparam logic [1:0] OPC_CLR  = 2'b00;
  localparam logic [1:0] OPC_HOLD = 2'b01;
  localparam logic [1:0] OPC_INC  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_CONVERT, S_WAIT_ADC,
    S_STORE, S_NEXT_COL, S_NEXT_ROW, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      tmo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      tmo_q    <= tmo_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    opc_row_o   = OPC_HOLD;
    opc_col_o   = OPC_HOLD;
    adc_start_o = 1'b0;
    wr_en_o     = 1'b0;
    done_o      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CLEAR;
          err_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        opc_row_o = OPC_CLR;
        opc_col_o = OPC_CLR;
        state_d   = S_SETTLE;
        settle_d  = SETTLE_LD;
      end
      S_SETTLE: begin
        if (settle_q == '0) state_d = S_CONVERT;
        else                settle_d = settle_q - SW'(1);
      end
      S_CONVERT: begin
        adc_start_o = 1'b1;
        state_d     = S_WAIT_ADC;
        tmo_d       = TMO_LD;
      end
      S_WAIT_ADC: begin
        // A conversion finishing on the expiry cycle still counts as success.
        if (adc_done_i) state_d = S_STORE;
        else if (tmo_q == '0) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else tmo_d = tmo_q - TW'(1);
      end
      S_STORE: begin
        wr_en_o = 1'b1;
        if (col_cnt_i == COL_LAST)
          state_d = (row_cnt_i == ROW_LAST) ? S_DONE : S_NEXT_ROW;
        else
          state_d = S_NEXT_COL;
      end
      S_NEXT_COL: begin
        opc_col_o = OPC_INC;
        state_d   = S_SETTLE;
        settle_d  = SETTLE_LD;
      end
      S_NEXT_ROW: begin
        opc_col_o = OPC_CLR;
        opc_row_o = OPC_INC;
        state_d   = S_SETTLE;
        settle_d  = SETTLE_LD;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything, including a timeout that would set err.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign err_o  = err_q;

endmodule
